// File: rtl/alu_shifter_if.sv
// rtl/alu_shifter_if.sv - operand/result bundle between execute stage and the barrel shifter
interface alu_shifter_if;
    logic [15:0] shift_in;
    logic [3:0]  shift_val;
    logic [1:0]  mode;
    logic [15:0] shift_out;
    logic [2:0]  flag;

    modport master (
        output shift_in,
        output shift_val,
        output mode,
        input  shift_out,
        input  flag
    );

    modport slave (
        input  shift_in,
        input  shift_val,
        input  mode,
        output shift_out,
        output flag
    );
endinterface

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - 16-bit SLL/SRA/ROR barrel shifter with registered result and N/V/Z flags
module alu_shifter (
    input  logic           clk,
    input  logic           rst_n,
    alu_shifter_if.slave   sh_if
);
    typedef enum logic [1:0] {
        MODE_SLL  = 2'b00,
        MODE_SRA  = 2'b01,
        MODE_ROR  = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    mode_e       mode;
    logic [15:0] res_d;
    logic [4:0]  amt;
    logic [15:0] shift_out_q;
    logic [2:0]  flag_q;
    logic [2:0]  flag_d;

    assign mode = mode_e'(sh_if.mode);

    // Four cascaded stages of distance 1/2/4/8; SRA fill always uses the original sign bit.
    always_comb begin
        res_d = sh_if.shift_in;
        amt   = 5'd0;
        for (int k = 0; k < 4; k++) begin
            amt = 5'd1 << k;
            if (sh_if.shift_val[k]) begin
                unique case (mode)
                    MODE_SLL:  res_d = res_d << amt;
                    MODE_SRA:  res_d = (res_d >> amt) |
                                       (sh_if.shift_in[15] ? ~(16'hFFFF >> amt) : 16'h0000);
                    MODE_ROR:  res_d = (res_d >> amt) | (res_d << (5'd16 - amt));
                    MODE_PASS: res_d = res_d;
                endcase
            end
        end
    end

    always_comb begin
        flag_d    = 3'b000;
        flag_d[2] = res_d[15];
        flag_d[1] = 1'b0;
        flag_d[0] = (res_d == 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_out_q <= 16'h0000;
            flag_q      <= 3'b000;
        end else begin
            shift_out_q <= res_d;
            flag_q      <= flag_d;
        end
    end

    assign sh_if.shift_out = shift_out_q;
    assign sh_if.flag      = flag_q;
endmodule

// File: tb/tb_alu_shifter.sv
// tb/tb_alu_shifter.sv - directed self-checking bench for alu_shifter
module tb_alu_shifter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_shifter_if sh();

    alu_shifter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sh_if (sh.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [15:0] d, input logic [3:0] v, input logic [1:0] m);
        @(negedge clk);
        sh.shift_in  = d;
        sh.shift_val = v;
        sh.mode      = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (sh.shift_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_out got=%h exp=0000", sh.shift_out);
        end
        checks++;
        if (sh.flag !== 3'b000) begin
            failures++;
            $display("FAIL reset_flag got=%b exp=000", sh.flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ror();
        logic [3:0]  v[4]   = '{4'h0, 4'h4, 4'h8, 4'hC};
        logic [15:0] e[4]   = '{16'h1234, 16'h4123, 16'h3412, 16'h2341};
        for (int i = 0; i < 4; i++) begin
            drive(16'h1234, v[i], 2'b10);
            checks++;
            if (sh.shift_out !== e[i]) begin
                failures++;
                $display("FAIL ror_out[%0d] got=%h exp=%h", i, sh.shift_out, e[i]);
            end
            checks++;
            if (sh.flag !== 3'b000) begin
                failures++;
                $display("FAIL ror_flag[%0d] got=%b exp=000", i, sh.flag);
            end
        end
        drive(16'h0001, 4'h1, 2'b10);
        checks++;
        if (sh.shift_out !== 16'h8000 || sh.flag !== 3'b100) begin
            failures++;
            $display("FAIL ror_wrap got=%h/%b exp=8000/100", sh.shift_out, sh.flag);
        end
    endtask

    task automatic test_sll();
        logic [15:0] d[4] = '{16'h1234, 16'h1234, 16'h1234, 16'h0001};
        logic [3:0]  v[4] = '{4'h5, 4'hF, 4'h4, 4'hF};
        logic [15:0] e[4] = '{16'h4680, 16'h0000, 16'h2340, 16'h8000};
        logic [2:0]  f[4] = '{3'b000, 3'b001, 3'b000, 3'b100};
        for (int i = 0; i < 4; i++) begin
            drive(d[i], v[i], 2'b00);
            checks++;
            if (sh.shift_out !== e[i] || sh.flag !== f[i]) begin
                failures++;
                $display("FAIL sll[%0d] got=%h/%b exp=%h/%b", i, sh.shift_out, sh.flag, e[i], f[i]);
            end
        end
    endtask

    task automatic test_sra();
        logic [15:0] d[4] = '{16'h8000, 16'h1234, 16'h1234, 16'hF000};
        logic [3:0]  v[4] = '{4'hF, 4'h2, 4'hD, 4'h3};
        logic [15:0] e[4] = '{16'hFFFF, 16'h048D, 16'h0000, 16'hFE00};
        logic [2:0]  f[4] = '{3'b100, 3'b000, 3'b001, 3'b100};
        for (int i = 0; i < 4; i++) begin
            drive(d[i], v[i], 2'b01);
            checks++;
            if (sh.shift_out !== e[i] || sh.flag !== f[i]) begin
                failures++;
                $display("FAIL sra[%0d] got=%h/%b exp=%h/%b", i, sh.shift_out, sh.flag, e[i], f[i]);
            end
        end
    endtask

    task automatic test_pass();
        logic [15:0] d[4] = '{16'hA5A5, 16'h8001, 16'h8001, 16'h0000};
        logic [3:0]  v[4] = '{4'h7, 4'h0, 4'h0, 4'h0};
        logic [1:0]  m[4] = '{2'b11, 2'b00, 2'b01, 2'b10};
        logic [15:0] e[4] = '{16'hA5A5, 16'h8001, 16'h8001, 16'h0000};
        logic [2:0]  f[4] = '{3'b100, 3'b100, 3'b100, 3'b001};
        for (int i = 0; i < 4; i++) begin
            drive(d[i], v[i], m[i]);
            checks++;
            if (sh.shift_out !== e[i] || sh.flag !== f[i]) begin
                failures++;
                $display("FAIL pass[%0d] got=%h/%b exp=%h/%b", i, sh.shift_out, sh.flag, e[i], f[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(16'hA5A5, 4'h0, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sh.shift_out !== 16'h0000 || sh.flag !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid got=%h/%b exp=0000/000", sh.shift_out, sh.flag);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sh.shift_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0000", sh.shift_out);
        end
        sh.shift_in  = 16'h1234;
        sh.shift_val = 4'h4;
        sh.mode      = 2'b10;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sh.shift_out !== 16'h4123 || sh.flag !== 3'b000) begin
            failures++;
            $display("FAIL reset_release got=%h/%b exp=4123/000", sh.shift_out, sh.flag);
        end
    endtask

    task automatic test_latency();
        drive(16'h1234, 4'h5, 2'b00);
        #2;
        sh.shift_in  = 16'h8000;
        sh.shift_val = 4'hF;
        sh.mode      = 2'b01;
        #1;
        checks++;
        if (sh.shift_out !== 16'h4680 || sh.flag !== 3'b000) begin
            failures++;
            $display("FAIL latency_hold got=%h/%b exp=4680/000", sh.shift_out, sh.flag);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sh.shift_out !== 16'hFFFF || sh.flag !== 3'b100) begin
            failures++;
            $display("FAIL latency_update got=%h/%b exp=FFFF/100", sh.shift_out, sh.flag);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        sh.shift_in  = 16'h0000;
        sh.shift_val = 4'h0;
        sh.mode      = 2'b00;
        test_reset();
        test_ror();
        test_sll();
        test_sra();
        test_pass();
        test_reset_mid();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
